// File: rtl/instr_encoder.sv
// RV32I field packer: encodes split instruction fields into 32-bit words and
// streams them, tagged with a sequential word address, through a 2-entry buffer.
module instr_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [4:0]        rd,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic              err_misalign
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic              init_done;
    logic [1:0]        count;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       mem_instr [2];
    logic [ADDR_W-1:0] mem_addr  [2];

    logic [31:0] enc;
    logic        legal;
    logic        misalign;
    logic        accept;
    logic        push;
    logic        xfer;

    always_comb begin
        enc      = '0;
        legal    = 1'b1;
        misalign = 1'b0;
        case (opcode)
            OP_R:
                enc = {func7, rs2, rs1, func3, rd, opcode};
            OP_IMM: begin
                if (func3 == 3'b001 || func3 == 3'b101)
                    enc = {func7, imm[4:0], rs1, func3, rd, opcode};
                else
                    enc = {imm[11:0], rs1, func3, rd, opcode};
            end
            OP_LOAD, OP_JALR:
                enc = {imm[11:0], rs1, func3, rd, opcode};
            OP_STORE:
                enc = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            OP_BRANCH: begin
                enc      = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
                misalign = imm[0];
            end
            OP_LUI, OP_AUIPC:
                enc = {imm[31:12], rd, opcode};
            OP_JAL: begin
                enc      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                misalign = imm[0];
            end
            default:
                legal = 1'b0;
        endcase
    end

    // in_ready is held low until the first edge after reset release
    assign in_ready  = init_done && (count != 2'd2) && !clear;
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign xfer      = out_valid && out_ready;

    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_addr  = out_valid ? mem_addr[rd_ptr]  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done    <= 1'b0;
            count        <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            addr_cnt     <= '0;
            err_illegal  <= 1'b0;
            err_misalign <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (clear) begin
                count        <= '0;
                rd_ptr       <= 1'b0;
                wr_ptr       <= 1'b0;
                addr_cnt     <= '0;
                err_illegal  <= 1'b0;
                err_misalign <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr   <= ~wr_ptr;
                    addr_cnt <= addr_cnt + 1'b1;
                end
                if (xfer)
                    rd_ptr <= ~rd_ptr;
                case ({push, xfer})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
                if (accept && !legal)
                    err_illegal <= 1'b1;
                if (accept && legal && misalign)
                    err_misalign <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= enc;
            mem_addr[wr_ptr]  <= addr_cnt;
        end
    end

endmodule
